demux1a8_reg: RTL

Eight-entry 1-to-8 demultiplexing register bank for the matrix-vector datapath. It accepts a stream of uint16_t words over a valid/ready handshake and steers each accepted word into one of eight holding registers. Targeting is either sequential (auto-increment) or addressed by `sel`. The eight registers drive the parallel operand buses that the 8:1 selection muxes read. A `full` flag tells the controller when a complete 8-element vector is loaded.

---
 rtl/demux1a8_reg.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/demux1a8_reg.sv
// demux1a8_reg -- eight-entry 1-to-8 demultiplexing register bank.
//
// Accepts a stream of 16-bit words over a valid/ready handshake and steers
// each accepted word into one of eight holding registers. The target index
// either auto-increments from 0 (AUTO_INC=1) or comes from `sel` (AUTO_INC=0).
// Once all eight registers have been written, the bank stops accepting
// words and raises `full` until the next `clear` or reset.
//
// Ports:
//   clk                 rising-edge clock
//   rst_n               synchronous active-low reset (zeroes data)
//   clear               synchronous restart of a vector load (data kept)
//   in_valid / in_ready handshake; a word is taken when both are high
//   in_data             16-bit word to store
//   sel                 target index, used only when AUTO_INC=0
//   a_output..h_output  registers 0..7
//   valid_mask          bit i set once register i is written
//   wr_idx              index the next accepted word will go to
//   full                all eight registers written

package mxv_pkg;
    typedef logic [15:0] uint16_t;
endpackage

module demux1a8_reg
    import mxv_pkg::*;
#(
    parameter int AUTO_INC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       in_valid,
    input  uint16_t    in_data,
    input  logic [2:0] sel,
    output logic       in_ready,
    output uint16_t    a_output,
    output uint16_t    b_output,
    output uint16_t    c_output,
    output uint16_t    d_output,
    output uint16_t    e_output,
    output uint16_t    f_output,
    output uint16_t    g_output,
    output uint16_t    h_output,
    output logic [7:0] valid_mask,
    output logic [2:0] wr_idx,
    output logic       full
);

    typedef enum logic {
        LOAD = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t     state_reg;
    state_t     state_next;
    logic [7:0] mask_reg;
    logic [7:0] mask_next;
    logic [2:0] wr_target;
    logic [7:0] target_onehot;
    logic       accept;
    uint16_t    bank [8];

    // clear takes priority over an arriving word: ready drops in the same
    // cycle so the producer keeps the word for the restarted load.
    assign in_ready = (state_reg == LOAD) && !clear && rst_n;
    assign accept   = in_valid && in_ready;

    assign target_onehot = 8'b0000_0001 << wr_target;

    // ------------------------------------------------------------------
    // Write index: a counter in sequential mode, a straight wire from sel
    // in addressed mode.
    // ------------------------------------------------------------------
    generate
        if (AUTO_INC != 0) begin : g_auto
            logic [2:0] idx_reg;
            logic       unused_sel;

            assign unused_sel = ^sel;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    idx_reg <= 3'd0;
                end else if (clear) begin
                    idx_reg <= 3'd0;
                end else if (accept) begin
                    // Wraps 7 -> 0; the bank goes FULL on that same accept.
                    idx_reg <= idx_reg + 3'd1;
                end
            end

            assign wr_target = idx_reg;
            assign wr_idx    = idx_reg;
        end else begin : g_addr
            assign wr_target = sel;
            assign wr_idx    = sel;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        mask_next  = mask_reg;
        if (accept) begin
            mask_next = mask_reg | target_onehot;
        end
        case (state_reg)
            LOAD: begin
                if (accept && (mask_next == 8'hFF)) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                state_next = FULL;
            end
            default: begin
                state_next = LOAD;
            end
        endcase
        if (clear) begin
            state_next = LOAD;
            mask_next  = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= LOAD;
            mask_reg  <= 8'h00;
        end else begin
            state_reg <= state_next;
            mask_reg  <= mask_next;
        end
    end

    // ------------------------------------------------------------------
    // Data registers: only an accept addressed to the entry, or reset,
    // changes its contents. clear leaves them untouched.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bank
            uint16_t data_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    data_reg <= 16'h0000;
                end else if (accept && (wr_target == gi[2:0])) begin
                    data_reg <= in_data;
                end
            end

            assign bank[gi] = data_reg;
        end
    endgenerate

    assign a_output   = bank[0];
    assign b_output   = bank[1];
    assign c_output   = bank[2];
    assign d_output   = bank[3];
    assign e_output   = bank[4];
    assign f_output   = bank[5];
    assign g_output   = bank[6];
    assign h_output   = bank[7];
    assign valid_mask = mask_reg;
    assign full       = (state_reg == FULL);

endmodule
